// File: rtl/dtmf_tone_generator_if.sv
// Key-request and PCM-sample bundle between the control FSM, the DTMF tone
// generator and the codec sample path.
interface dtmf_tone_generator_if;
  logic               enable;
  logic [15:0]        tone;
  logic               sample_tick;
  logic               busy;
  logic               done;
  logic               error;
  logic signed [15:0] sample;
  logic               sample_valid;

  modport master (
    output enable, tone, sample_tick,
    input  busy, done, error, sample, sample_valid
  );

  modport slave (
    input  enable, tone, sample_tick,
    output busy, done, error, sample, sample_valid
  );
endinterface

// File: rtl/dtmf_tone_generator.sv
// DTMF dual-tone synthesiser: one key code in, a fixed-length burst of 16-bit
// PCM samples (two phase-accumulated sines) followed by a silent gap out.
module dtmf_tone_generator #(
  parameter int unsigned TONE_SAMPLES = 400,
  parameter int unsigned GAP_SAMPLES  = 400
) (
  input logic                  clock,
  input logic                  reset,
  dtmf_tone_generator_if.slave bus
);
  localparam logic [15:0] TONE_N = 16'(TONE_SAMPLES);
  localparam logic [15:0] GAP_N  = 16'(GAP_SAMPLES);

  typedef enum logic [1:0] {IDLE, TONE, GAP, DONE} state_e;

  state_e             state_q;
  logic [15:0]        inc_lo_q, inc_hi_q, acc_lo_q, acc_hi_q, cnt_q;
  logic [15:0]        acc_lo_d, acc_hi_d, cnt_d;
  logic signed [7:0]  lut_lo_p1, lut_hi_p1;
  logic               vld_p1;
  logic signed [8:0]  sum_p1;
  logic signed [15:0] sample_q;
  logic               sample_valid_q, busy_q, done_q, error_q;
  logic [4:0]         key;

  // {valid, row[1:0], col[1:0]} for the 4x4 keypad, row-major.
  function automatic logic [4:0] decode(input logic [15:0] code);
    if (code[15:8] != 8'h00) return 5'b0_00_00;
    case (code[7:0])
      8'h31: return 5'b1_00_00;  8'h32: return 5'b1_00_01;
      8'h33: return 5'b1_00_10;  8'h41: return 5'b1_00_11;
      8'h34: return 5'b1_01_00;  8'h35: return 5'b1_01_01;
      8'h36: return 5'b1_01_10;  8'h42: return 5'b1_01_11;
      8'h37: return 5'b1_10_00;  8'h38: return 5'b1_10_01;
      8'h39: return 5'b1_10_10;  8'h43: return 5'b1_10_11;
      8'h2A: return 5'b1_11_00;  8'h30: return 5'b1_11_01;
      8'h23: return 5'b1_11_10;  8'h44: return 5'b1_11_11;
      default: return 5'b0_00_00;
    endcase
  endfunction

  function automatic logic [15:0] row_inc(input logic [1:0] r);
    case (r)
      2'd0:    return 16'd5710;
      2'd1:    return 16'd6308;
      2'd2:    return 16'd6980;
      default: return 16'd7709;
    endcase
  endfunction

  function automatic logic [15:0] col_inc(input logic [1:0] c);
    case (c)
      2'd0:    return 16'd9904;
      2'd1:    return 16'd10945;
      2'd2:    return 16'd12100;
      default: return 16'd13378;
    endcase
  endfunction

  // round(127*sin(2*pi*i/256)) for the first quarter wave, i = 0..64.
  function automatic logic [6:0] quarter(input logic [6:0] i);
    case (i)
      7'd0:  return 7'd0;   7'd1:  return 7'd3;   7'd2:  return 7'd6;   7'd3:  return 7'd9;
      7'd4:  return 7'd12;  7'd5:  return 7'd16;  7'd6:  return 7'd19;  7'd7:  return 7'd22;
      7'd8:  return 7'd25;  7'd9:  return 7'd28;  7'd10: return 7'd31;  7'd11: return 7'd34;
      7'd12: return 7'd37;  7'd13: return 7'd40;  7'd14: return 7'd43;  7'd15: return 7'd46;
      7'd16: return 7'd49;  7'd17: return 7'd51;  7'd18: return 7'd54;  7'd19: return 7'd57;
      7'd20: return 7'd60;  7'd21: return 7'd63;  7'd22: return 7'd65;  7'd23: return 7'd68;
      7'd24: return 7'd71;  7'd25: return 7'd73;  7'd26: return 7'd76;  7'd27: return 7'd78;
      7'd28: return 7'd81;  7'd29: return 7'd83;  7'd30: return 7'd85;  7'd31: return 7'd88;
      7'd32: return 7'd90;  7'd33: return 7'd92;  7'd34: return 7'd94;  7'd35: return 7'd96;
      7'd36: return 7'd98;  7'd37: return 7'd100; 7'd38: return 7'd102; 7'd39: return 7'd104;
      7'd40: return 7'd106; 7'd41: return 7'd107; 7'd42: return 7'd109; 7'd43: return 7'd111;
      7'd44: return 7'd112; 7'd45: return 7'd113; 7'd46: return 7'd115; 7'd47: return 7'd116;
      7'd48: return 7'd117; 7'd49: return 7'd118; 7'd50: return 7'd120; 7'd51: return 7'd121;
      7'd52: return 7'd122; 7'd53: return 7'd122; 7'd54: return 7'd123; 7'd55: return 7'd124;
      7'd56: return 7'd125; 7'd57: return 7'd125; 7'd58: return 7'd126; 7'd59: return 7'd126;
      7'd60: return 7'd126; 7'd61: return 7'd127; 7'd62: return 7'd127; 7'd63: return 7'd127;
      7'd64: return 7'd127;
      default: return 7'd0;
    endcase
  endfunction

  // Full 256-entry sine by mirroring (odd quadrants) and negating (lower half).
  function automatic logic signed [7:0] sine(input logic [7:0] a);
    logic [6:0] idx;
    logic [7:0] mag;
    idx = a[6] ? (7'd64 - {1'b0, a[5:0]}) : {1'b0, a[5:0]};
    mag = {1'b0, quarter(idx)};
    return a[7] ? 8'(-mag) : mag;
  endfunction

  assign key      = decode(bus.tone);
  assign acc_lo_d = acc_lo_q + inc_lo_q;
  assign acc_hi_d = acc_hi_q + inc_hi_q;
  assign cnt_d    = cnt_q + 16'd1;
  assign sum_p1   = {lut_lo_p1[7], lut_lo_p1} + {lut_hi_p1[7], lut_hi_p1};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      inc_lo_q       <= '0;
      inc_hi_q       <= '0;
      acc_lo_q       <= '0;
      acc_hi_q       <= '0;
      cnt_q          <= '0;
      lut_lo_p1      <= '0;
      lut_hi_p1      <= '0;
      vld_p1         <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      error_q <= 1'b0;
      done_q  <= 1'b0;
      vld_p1  <= 1'b0;

      // Stage 2: sum of the two tone lookups, scaled into the 16-bit range.
      sample_valid_q <= vld_p1;
      if (vld_p1) sample_q <= {sum_p1[8], sum_p1, 6'b0};

      // Stage 1: LUT read at the current phases (or forced silence in GAP).
      unique case (state_q)
        IDLE: begin
          if (bus.enable) begin
            if (key[4]) begin
              inc_lo_q <= row_inc(key[3:2]);
              inc_hi_q <= col_inc(key[1:0]);
              acc_lo_q <= '0;
              acc_hi_q <= '0;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= TONE;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        TONE: begin
          if (bus.sample_tick) begin
            lut_lo_p1 <= sine(acc_lo_q[15:8]);
            lut_hi_p1 <= sine(acc_hi_q[15:8]);
            vld_p1    <= 1'b1;
            acc_lo_q  <= acc_lo_d;
            acc_hi_q  <= acc_hi_d;
            if (cnt_d == TONE_N) begin
              cnt_q   <= '0;
              state_q <= (GAP_N == 16'd0) ? DONE : GAP;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        GAP: begin
          if (bus.sample_tick) begin
            lut_lo_p1 <= '0;
            lut_hi_p1 <= '0;
            vld_p1    <= 1'b1;
            if (cnt_d == GAP_N) begin
              cnt_q   <= '0;
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        DONE: begin
          // Hold off done until the last sample has left stage 1.
          if (!vld_p1) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = sample_valid_q;
endmodule

// File: tb/tb_dtmf_tone_generator.sv
// Scoreboard bench for dtmf_tone_generator: two instances (tone 4 / gap 2 and
// tone 3 / gap 0) driven with directed and randomized key requests.
module tb_dtmf_tone_generator;
  localparam real PI = 3.14159265358979323846;

  typedef struct {
    int inst;
    int val;
    int cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  string KEYS = "123A456B789C*0#D";

  logic               en[2];
  logic [15:0]        tn[2];
  logic               tk[2];
  logic               vld_o[2], busy_o[2], done_o[2], err_o[2];
  logic signed [15:0] smp_o[2];

  dtmf_tone_generator_if ifa ();
  dtmf_tone_generator_if ifb ();

  assign ifa.enable = en[0];
  assign ifa.tone = tn[0];
  assign ifa.sample_tick = tk[0];
  assign ifb.enable = en[1];
  assign ifb.tone = tn[1];
  assign ifb.sample_tick = tk[1];
  assign vld_o[0] = ifa.sample_valid;
  assign busy_o[0] = ifa.busy;
  assign done_o[0] = ifa.done;
  assign err_o[0] = ifa.error;
  assign smp_o[0] = ifa.sample;
  assign vld_o[1] = ifb.sample_valid;
  assign busy_o[1] = ifb.busy;
  assign done_o[1] = ifb.done;
  assign err_o[1] = ifb.error;
  assign smp_o[1] = ifb.sample;

  dtmf_tone_generator #(.TONE_SAMPLES(4), .GAP_SAMPLES(2)) dut_a (
    .clock(clock), .reset(reset), .bus(ifa));
  dtmf_tone_generator #(.TONE_SAMPLES(3), .GAP_SAMPLES(0)) dut_b (
    .clock(clock), .reset(reset), .bus(ifb));

  int   tests = 0;
  int   fails = 0;
  exp_t sq[$];
  exp_t eq[$];
  int   pending_done = 0;
  int   done_inst = 0;
  int   last_smp[2] = '{0, 0};
  exp_t e_m;

  function automatic int nt(int inst); return (inst == 0) ? 4 : 3; endfunction
  function automatic int ng(int inst); return (inst == 0) ? 2 : 0; endfunction

  function automatic int row_hz_inc(int r);
    case (r) 0: return 5710; 1: return 6308; 2: return 6980; default: return 7709; endcase
  endfunction
  function automatic int col_hz_inc(int c);
    case (c) 0: return 9904; 1: return 10945; 2: return 12100; default: return 13378; endcase
  endfunction

  function automatic int lut_ref(int i);
    real r;
    r = 127.0 * $sin(2.0 * PI * real'(i) / 256.0);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  // Sample k of a burst: both phases are k*increment mod 2^16.
  function automatic int exp_sample(int key, int k);
    longint pl, ph;
    pl = (longint'(k) * longint'(row_hz_inc(key / 4))) % 65536;
    ph = (longint'(k) * longint'(col_hz_inc(key % 4))) % 65536;
    return (lut_ref(int'(pl / 256)) + lut_ref(int'(ph / 256))) * 64;
  endfunction

  function automatic bit is_valid(logic [15:0] code);
    if (code[15:8] != 8'h00) return 1'b0;
    for (int i = 0; i < 16; i++) if (KEYS[i] == code[7:0]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int outs(int g);
    return int'(busy_o[g]) + int'(done_o[g]) + int'(err_o[g]) + int'(vld_o[g]) +
           ((smp_o[g] != 16'sd0) ? 1 : 0);
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a sample, done or error.
  always @(negedge clock) begin
    if (reset) begin
      for (int g = 0; g < 2; g++) begin
        if (vld_o[g]) begin
          if (sq.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_sample inst%0d: got sample %0d, required none", g, smp_o[g]);
          end else begin
            e_m = sq.pop_front();
            check("sample_inst", g, e_m.inst);
            check("sample_value", int'(smp_o[g]), e_m.val);
            check("sample_latency_cycle", cyc, e_m.cyc);
            check("busy_during_burst", int'(busy_o[g]), 1);
          end
          last_smp[g] = int'(smp_o[g]);
        end else begin
          check("sample_hold", int'(smp_o[g]), last_smp[g]);
        end
        if (done_o[g]) begin
          if (pending_done == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_done inst%0d: got done pulse, required none", g);
          end else begin
            pending_done--;
            check("done_inst", g, done_inst);
            check("done_after_last_sample", sq.size(), 0);
          end
        end
        if (err_o[g]) begin
          if (eq.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_error inst%0d: got error pulse, required none", g);
          end else begin
            e_m = eq.pop_front();
            check("error_inst", g, e_m.inst);
            check("error_cycle", cyc, e_m.cyc);
          end
        end
      end
    end else begin
      last_smp[0] = 0;
      last_smp[1] = 0;
    end
  end

  task automatic wait_done(input int inst);
    int n;
    n = 0;
    while (pending_done != 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (pending_done != 0) begin
      tests++; fails++;
      $display("FAIL done_timeout inst%0d: got no done in 60 cycles, required one", inst);
      pending_done = 0;
      sq.delete();
    end
    @(negedge clock);
    check("busy_after_done", int'(busy_o[inst]), 0);
  endtask

  task automatic run_burst(input int inst, input int key, input int spacing,
                           input bit acc_tick, input bit mid_en, input bit extra);
    exp_t e;
    int   tot;
    tot = nt(inst) + ng(inst);
    done_inst = inst;
    pending_done++;
    en[inst] = 1'b1;
    tn[inst] = {8'h00, KEYS[key]};
    tk[inst] = acc_tick;
    @(negedge clock);
    en[inst] = 1'b0;
    tk[inst] = 1'b0;
    for (int k = 0; k < tot; k++) begin
      repeat (spacing - 1) @(negedge clock);
      tk[inst] = 1'b1;
      e.inst = inst;
      e.val  = (k < nt(inst)) ? exp_sample(key, k) : 0;
      e.cyc  = cyc + 2;
      sq.push_back(e);
      if (mid_en && k == 1) begin
        en[inst] = 1'b1;
        tn[inst] = 16'h0023;
      end
      @(negedge clock);
      tk[inst] = 1'b0;
      en[inst] = 1'b0;
    end
    if (extra) begin
      tk[inst] = 1'b1;
      @(negedge clock);
      tk[inst] = 1'b0;
    end
    wait_done(inst);
  endtask

  task automatic bad_key(input int inst, input logic [15:0] code);
    exp_t e;
    e.inst = inst;
    e.val  = 0;
    e.cyc  = cyc + 1;
    eq.push_back(e);
    en[inst] = 1'b1;
    tn[inst] = code;
    @(negedge clock);
    en[inst] = 1'b0;
    repeat (2) @(negedge clock);
    check("busy_after_bad_key", int'(busy_o[inst]), 0);
  endtask

  function automatic logic [15:0] rand_invalid();
    logic [15:0] code;
    code = 16'($urandom);
    if ($urandom_range(0, 1) == 1) code[15:8] = 8'h00;
    if (is_valid(code)) code[8] = 1'b1;
    return code;
  endfunction

  initial begin
    exp_t e;
    int   key;
    en[0] = 1'b0; en[1] = 1'b0;
    tk[0] = 1'b0; tk[1] = 1'b0;
    tn[0] = '0;   tn[1] = '0;
    #1 reset = 1'b0;

    // Held in reset with requests and ticks applied: everything stays quiet.
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      for (int g = 0; g < 2; g++) begin
        check("reset_hold_outputs", outs(g), 0);
        en[g] = 1'b1;
        tn[g] = 16'h0035;
        tk[g] = i[0];
      end
    end
    @(negedge clock);
    en[0] = 1'b0; en[1] = 1'b0; tk[0] = 1'b0; tk[1] = 1'b0;
    reset = 1'b1;
    repeat (5) @(negedge clock);

    run_burst(0, 5, 10, 1'b0, 1'b0, 1'b1);   // '5', slow ticks
    bad_key(0, 16'h0045);
    bad_key(0, 16'h0131);
    run_burst(0, 0, 3, 1'b1, 1'b1, 1'b0);    // '1' with '#' mid-burst
    run_burst(1, 15, 1, 1'b0, 1'b0, 1'b1);   // 'D', back-to-back ticks, no gap

    for (int i = 0; i < 16; i++) begin
      int inst;
      inst = int'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) bad_key(inst, rand_invalid());
      else run_burst(inst, int'($urandom_range(0, 15)), int'($urandom_range(1, 4)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a burst.
    key = int'($urandom_range(0, 15));
    done_inst = 0;
    pending_done++;
    en[0] = 1'b1;
    tn[0] = {8'h00, KEYS[key]};
    @(negedge clock);
    en[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tk[0] = 1'b1;
      e.inst = 0;
      e.val  = exp_sample(key, k);
      e.cyc  = cyc + 2;
      sq.push_back(e);
      @(negedge clock);
      tk[0] = 1'b0;
    end
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    #1 check("async_reset_outputs", outs(0), 0);
    pending_done = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run_burst(0, 13, 2, 1'b0, 1'b0, 1'b0);   // '0' after reset

    repeat (4) @(negedge clock);
    check("samples_outstanding", sq.size(), 0);
    check("errors_outstanding", eq.size(), 0);
    check("dones_outstanding", pending_done, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dtmf_tone_generator.md
Name: dtmf_tone_generator

Overview:
- Transmit-side counterpart of the DTMF tone detection path: takes one key code and synthesises the matching dual-tone waveform as a stream of 16-bit signed PCM samples.
- One sample is produced per external sample strobe (8 kHz system rate).
- Each key produces a fixed-length tone burst followed by a silent inter-digit gap, then signals done.
- Sits between the control FSM (key source) and the DAC/codec sample interface.

Parameters:
- TONE_SAMPLES, 400, tone burst length in sample ticks (50 ms at 8 kHz); range 1..65535.
- GAP_SAMPLES, 400, silent gap length in sample ticks; range 0..65535, 0 = no gap.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  start request; sampled only in IDLE.
- tone  in  16  key code: ASCII character in [7:0]; [15:8] must be 0.
- sample_tick  in  1  one-clock strobe at the 8 kHz sample rate.
- busy  out  1  high in TONE and GAP.
- done  out  1  one-clock pulse when the gap completes.
- error  out  1  one-clock pulse when a start request has an invalid code.
- sample  out  16  signed PCM sample.
- sample_valid  out  1  one-clock pulse when sample is updated.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - busy, done, error, sample_valid and sample all go to 0.
  - Phase accumulators and counters clear.
  - Reset mid-burst aborts the burst with no done.
- Key decode:
  - Valid characters: '1','2','3','A','4','5','6','B','7','8','9','C','*','0','#','D'.
  - These map to row index 0-3 and column index 0-3 in that row-major order.
  - Any other value, or [15:8] != 0, is invalid.
- Phase increments (16-bit accumulator, 8 kHz):
  - Rows: 697 Hz = 5710, 770 Hz = 6308, 852 Hz = 6980, 941 Hz = 7709.
  - Columns: 1209 Hz = 9904, 1336 Hz = 10945, 1477 Hz = 12100, 1633 Hz = 13378.
- Sine LUT:
  - 256 entries, 8-bit signed, entry i = round(127*sin(2*pi*i/256)).
  - Addressed by accumulator[15:8].
- States:
  - IDLE: enable with a valid code latches both increments, clears both accumulators and the counter, and moves to TONE. enable with an invalid code pulses error the next cycle and stays in IDLE.
  - TONE: on each sample_tick, look up both tones at the current phases, then add the increments (modulo 2^16) and increment the counter. After the tick that makes counter = TONE_SAMPLES, clear the counter and go to GAP, or go to DONE if GAP_SAMPLES = 0.
  - GAP: on each tick, emit sample 0 with sample_valid and increment the counter. At counter = GAP_SAMPLES, go to DONE.
  - DONE: one cycle; done=1, then IDLE.
- Sample arithmetic:
  - sum = lut_low + lut_high (9-bit signed).
  - sample = sign-extended sum shifted left 6; peak magnitude 16256.
- Latency: sample_valid rises exactly 2 clocks after the clock in which sample_tick=1 (register stage 1 = LUT read, stage 2 = sum).
- The first sample of a burst uses phase 0 on both tones, so it is 0.
- sample holds its value between valid pulses.
- Boundary conditions:
  - enable while busy: ignored, no error.
  - sample_tick in the same cycle as the accepting enable: ignored; the burst's first sample comes from the next tick.
  - Two ticks 1 clock apart: both are processed; the pipeline accepts one tick per clock.
  - The final tone samples and the DONE transition drain the pipeline in order: done never precedes the last sample_valid of the burst.
  - Accumulator overflow wraps silently.

Test Plan:
- Reset: hold reset=0 with enable=1, ticks toggling -> all outputs 0, busy stays 0. Release reset -> IDLE, no spurious pulses.
- Key '5' (tone=16'h0035), TONE_SAMPLES=4, GAP_SAMPLES=2, ticks every 10 clocks:
  - Samples 0, 11520 ((71+109)*64), then next values per the LUT.
  - 2 zero-valued gap samples, then done pulse; busy is high from the cycle after enable until done.
- Invalid code tone=16'h0045 ('E'), then 16'h0131 -> error pulse 1 clock after each enable; busy stays 0; no sample_valid.
- enable with '1' asserted again mid-TONE with '#' -> the second request is ignored; the burst stays 697/1209 for the full TONE_SAMPLES; exactly one done.
- GAP_SAMPLES=0, key 'D', TONE_SAMPLES=3 -> 3 valid samples, then done with no zero samples. Also the latency check: each sample_valid arrives exactly 2 clocks after its tick, including back-to-back ticks.
- Reset asserted mid-TONE -> outputs 0 immediately (asynchronous), no done. After release, a new '0' request is accepted and its first sample is 0.
